// File: rtl/pipe_latch_skid.sv
// rtl/pipe_latch_skid.sv - pipeline-stage register for PC/instruction with valid/ready, flush and optional skid entry
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : upstream entry valid
//   in_ready   : stage can accept an entry this cycle
//   in_pc      : upstream PC
//   in_instr   : upstream instruction
//   flush      : synchronous kill of all held entries (bubble insertion)
//   out_valid  : out_pc/out_instr hold a valid entry
//   out_ready  : downstream accepts the entry this cycle
//   out_pc     : held PC
//   out_instr  : held instruction
//   drop_cnt   : saturating count of valid entries discarded by flush
module pipe_latch_skid #(
  parameter int unsigned         PC_W      = 7,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int                  SKID      = 1,
  parameter int unsigned         CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  logic [PC_W-1:0]     r_main_pc;
  logic [INSTR_W-1:0]  r_main_instr;
  logic [PC_W-1:0]     r_skid_pc;
  logic [INSTR_W-1:0]  r_skid_instr;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [CNT_W-1:0]    r_drop_cnt;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_issue;
  logic [1:0]          w_held;
  logic [1:0]          w_drop_n;
  logic [CNT_W:0]      w_cnt_sum;
  logic [CNT_W-1:0]    w_cnt_sat;

  // With the skid slot, in_ready comes straight from a flop so out_ready never
  // reaches upstream combinationally; without it, ready is the classic
  // "empty or draining" equation.
  if (SKID != 0) begin : g_skid
    assign w_in_ready = r_in_ready;
  end else begin : g_noskid
    assign w_in_ready = ~r_out_valid | out_ready;
  end

  assign w_accept = in_valid & w_in_ready;
  assign w_issue  = r_out_valid & out_ready;

  // Entries killed by a flush: everything held, except one that downstream
  // takes on the same edge (an issue implies at least one entry is held).
  assign w_held    = (r_state == S_TWO) ? 2'd2 :
                     (r_state == S_ONE) ? 2'd1 : 2'd0;
  assign w_drop_n  = w_held - {1'b0, w_issue};
  assign w_cnt_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_n);
  assign w_cnt_sat = w_cnt_sum[CNT_W] ? CNT_MAX : w_cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_drop_cnt   <= '0;
    end else if (flush) begin
      // Flush beats accept and issue; the input of this cycle is dropped.
      r_state      <= S_EMPTY;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_drop_cnt   <= w_cnt_sat;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
            r_state      <= S_ONE;
            r_out_valid  <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_issue) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
          end else if (w_accept) begin
            // Downstream stalled: park the new entry behind the main slot.
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
            r_state      <= S_TWO;
            r_in_ready   <= 1'b0;
          end else if (w_issue) begin
            // Payload keeps its last value while out_valid drops.
            r_state      <= S_EMPTY;
            r_out_valid  <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_issue) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
            r_state      <= S_ONE;
            r_in_ready   <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_main_pc;
  assign out_instr = r_main_instr;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pipe_latch_skid.sv
// tb/tb_pipe_latch_skid.sv - self-checking bench for pipe_latch_skid (skid and non-skid instances)
module tb_pipe_latch_skid;

  localparam logic [31:0] NOP_A = 32'h0000_0013;
  localparam logic [31:0] NOP_B = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [6:0]  a_out_pc;
  logic [31:0] a_out_instr;
  logic [1:0]  a_drop_cnt;

  logic        b_in_ready, b_out_valid;
  logic [6:0]  b_out_pc;
  logic [31:0] b_out_instr;
  logic [3:0]  b_drop_cnt;

  pipe_latch_skid #(
    .PC_W(7), .INSTR_W(32), .NOP_INSTR(NOP_A), .SKID(1), .CNT_W(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
    .drop_cnt(a_drop_cnt)
  );

  pipe_latch_skid #(
    .PC_W(7), .INSTR_W(32), .NOP_INSTR(NOP_B), .SKID(0), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .drop_cnt(b_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  // Model: per instance a FIFO of {pc, instr} of depth 2 (skid) or 1, the
  // payload last shown when empty, and the drop counter.
  logic [38:0] m_e    [2][2];
  logic [38:0] m_last [2];
  int          m_cnt  [2];
  int          m_drop [2];
  int          m_max  [2];
  logic [31:0] m_nop  [2];
  int          sat_exp [4] = '{1, 2, 3, 3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_max[0] = 3;
    m_max[1] = 15;
    m_nop[0] = NOP_A;
    m_nop[1] = NOP_B;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_drop[i] = 0;
      m_last[i] = {7'd0, m_nop[i]};
      m_e[i][0] = '0;
      m_e[i][1] = '0;
    end
  endtask

  function automatic logic exp_ready(input int i);
    if (i == 0) return m_cnt[0] < 2;
    return (m_cnt[1] == 0) || out_ready;
  endfunction

  function automatic logic [38:0] exp_payload(input int i);
    return (m_cnt[i] > 0) ? m_e[i][0] : m_last[i];
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int   sz;
      logic rdy, iss, acc;
      sz  = m_cnt[i];
      rdy = exp_ready(i);
      iss = (sz > 0) && out_ready;
      acc = in_valid && rdy;
      if (flush) begin
        m_drop[i] = m_drop[i] + sz - (iss ? 1 : 0);
        if (m_drop[i] > m_max[i]) m_drop[i] = m_max[i];
        m_cnt[i]  = 0;
        m_last[i] = {7'd0, m_nop[i]};
      end else begin
        if (iss) begin
          m_last[i] = m_e[i][0];
          m_e[i][0] = m_e[i][1];
          sz--;
        end
        if (acc) begin
          m_e[i][sz] = {in_pc, in_instr};
          sz++;
        end
        m_cnt[i] = sz;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_out_valid", 64'(a_out_valid), 64'(m_cnt[0] > 0));
      check("a_payload",   64'({a_out_pc, a_out_instr}), 64'(exp_payload(0)));
      check("a_in_ready",  64'(a_in_ready), 64'(exp_ready(0)));
      check("a_drop_cnt",  64'(a_drop_cnt), 64'(m_drop[0]));
      check("b_out_valid", 64'(b_out_valid), 64'(m_cnt[1] > 0));
      check("b_payload",   64'({b_out_pc, b_out_instr}), 64'(exp_payload(1)));
      check("b_in_ready",  64'(b_in_ready), 64'(exp_ready(1)));
      check("b_drop_cnt",  64'(b_drop_cnt), 64'(m_drop[1]));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    chk_en = 1'b1;
    tick();
    check("rst_a_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_a_out_pc",    64'(a_out_pc), 64'(0));
    check("rst_a_out_instr", 64'(a_out_instr), 64'(NOP_A));
    check("rst_a_drop_cnt",  64'(a_drop_cnt), 64'(0));
    check("rst_a_in_ready",  64'(a_in_ready), 64'(1));
    check("rst_b_in_ready",  64'(b_in_ready), 64'(1));
    rst = 1'b0;

    // Reset then stream with out_ready high.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_pc    = 7'(k + 1);
      in_instr = 32'hA0 + 32'(k);
      tick();
      check("stream_valid", 64'(a_out_valid), 64'(1));
      check("stream_pc",    64'(a_out_pc), 64'(k + 1));
      check("stream_instr", 64'(a_out_instr), 64'(32'hA0 + 32'(k)));
      check("stream_ready", 64'(a_in_ready), 64'(1));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", 64'(a_out_valid), 64'(0));
    check("stream_hold_pc",     64'(a_out_pc), 64'(4));

    // Backpressure into the skid slot.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 7'd5; in_instr = 32'hB5;
    tick();
    in_pc = 7'd6; in_instr = 32'hB6;
    tick();
    check("bp_ready_full", 64'(a_in_ready), 64'(0));
    check("bp_pc5",        64'(a_out_pc), 64'(5));
    in_pc = 7'd7; in_instr = 32'hB7;
    tick();
    check("bp_pc7_held",   64'(a_out_pc), 64'(5));
    out_ready = 1'b1;
    tick();
    check("bp_pc6",        64'(a_out_pc), 64'(6));
    check("bp_ready_back", 64'(a_in_ready), 64'(1));
    tick();
    check("bp_pc7",        64'(a_out_pc), 64'(7));
    in_valid = 1'b0;
    tick();
    check("bp_empty",      64'(a_out_valid), 64'(0));

    // Flush with two held entries and an input in the flush cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 7'd8; in_instr = 32'hC8;
    tick();
    in_pc = 7'd9; in_instr = 32'hC9;
    tick();
    check("fl_pre_cnt", 64'(a_drop_cnt), 64'(0));
    flush = 1'b1; in_pc = 7'd10; in_instr = 32'hCA;
    tick();
    check("fl_valid", 64'(a_out_valid), 64'(0));
    check("fl_pc",    64'(a_out_pc), 64'(0));
    check("fl_instr", 64'(a_out_instr), 64'(NOP_A));
    check("fl_cnt",   64'(a_drop_cnt), 64'(2));
    check("fl_ready", 64'(a_in_ready), 64'(1));
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_input_dropped", 64'(a_out_valid), 64'(0));

    // Saturation of the 2-bit counter.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 7'(40 + k); in_instr = 32'hD0 + 32'(k);
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      check("sat_cnt", 64'(a_drop_cnt), 64'(sat_exp[k]));
    end

    // Non-skid instance: combinational ready.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 7'd20; in_instr = 32'hE0;
    tick();
    in_valid = 1'b0;
    check("ns_valid", 64'(b_out_valid), 64'(1));
    check("ns_pc",    64'(b_out_pc), 64'(20));
    #1;
    check("ns_ready_low", 64'(b_in_ready), 64'(0));
    out_ready = 1'b1;
    #1;
    check("ns_ready_high", 64'(b_in_ready), 64'(1));
    in_valid = 1'b1; in_pc = 7'd21; in_instr = 32'hE1;
    tick();
    check("ns_pc21",    64'(b_out_pc), 64'(21));
    check("ns_valid21", 64'(b_out_valid), 64'(1));
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while the skid instance holds two entries.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 7'd30; in_instr = 32'hF0;
    tick();
    in_pc = 7'd31; in_instr = 32'hF1;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("ar_valid", 64'(a_out_valid), 64'(0));
    check("ar_instr", 64'(a_out_instr), 64'(NOP_A));
    check("ar_pc",    64'(a_out_pc), 64'(0));
    check("ar_ready", 64'(a_in_ready), 64'(1));
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_pc = 7'd32; in_instr = 32'hF2; out_ready = 1'b1;
    tick();
    check("ar_first_valid", 64'(a_out_valid), 64'(1));
    check("ar_first_pc",    64'(a_out_pc), 64'(32));
    in_valid = 1'b0;

    // Randomized traffic with occasional flushes and asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        flush = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 19) == 0);
        in_pc     = 7'($urandom);
        in_instr  = $urandom;
        tick();
      end
    end
    flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_latch_skid.md
Name: pipe_latch_skid

Overview:
- Parametrised successor to the fixed IF/ID latch; generic pipeline-stage register carrying a PC and an instruction word between stages.
- Adds a valid/ready handshake and synchronous flush with bubble insertion.
- Optional 2-entry skid buffer so backpressure does not create a combinational ready path.
- Saturating counter of entries discarded by flush, used for branch-penalty statistics.

Parameters:
- PC_W, 7, width of PC field.
- INSTR_W, 32, width of instruction field.
- NOP_INSTR, 0, instruction value driven on out_instr after reset or flush (bubble).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry, in_ready combinational.
- CNT_W, 8, width of drop_cnt.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_pc  input  PC_W  upstream PC.
- in_instr  input  INSTR_W  upstream instruction.
- flush  input  1  synchronous kill of all held entries.
- out_valid  output  1  out_pc/out_instr hold a valid entry.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_pc  output  PC_W  held PC.
- out_instr  output  INSTR_W  held instruction.
- drop_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Handshakes:
  - Accept: in_valid & in_ready at a rising clk edge.
  - Issue: out_valid & out_ready at a rising clk edge.
  - Order is strict FIFO.
- Reset (asynchronous, takes effect immediately while rst is high):
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, drop_cnt=0.
  - Skid entry emptied.
  - in_ready=1 when SKID=1; when SKID=0, follows its equation, giving 1.
- Reset mid-transfer: the entry is lost. No issue is reported for a cycle in which rst is high.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept: out_* <= in_*, out_valid <= 1, one-cycle latency.
  - Issue without accept: out_valid <= 0, payload holds its last value.
- SKID=1 (states EMPTY, ONE, TWO; two storage slots, main drives out_*, skid is hidden):
  - EMPTY: accept -> main <= in, ONE.
  - ONE, accept & issue -> main <= in, stay ONE.
  - ONE, accept & no issue -> skid <= in, TWO.
  - ONE, issue only -> EMPTY; payload holds.
  - TWO: in_ready=0, no accept. Issue -> main <= skid, ONE.
  - in_ready is registered: in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - Latency in to out: 1 cycle.
  - Full throughput with out_ready held high.
- Flush (synchronous, highest priority over accept and issue):
  - Next state EMPTY; out_valid=0; out_pc=0; out_instr=NOP_INSTR.
  - An input presented in the flush cycle is dropped, even if in_valid & in_ready.
  - An issue in the flush cycle is still counted by downstream (out_valid was 1 at that edge).
  - drop_cnt += number of valid entries held before the edge (0, 1 or 2), minus 1 if an issue occurred that edge.
  - drop_cnt saturates at 2^CNT_W-1; no wrap.
  - in_ready=1 the cycle after a flush.
- No X propagation: every register has an explicit reset value.

Test Plan:
- Reset then stream: SKID=1, rst pulse, then in_valid=1 with pc 1..4 and instr 0xA0..0xA3, out_ready=1 -> out_valid rises 1 cycle after the first accept; out_pc 1,2,3,4 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0, push pc=5, then pc=6 -> in_ready=0 after the second accept; pc=7 is held off. out_ready=1 -> pc 5, then 6, then 7 issued in order, none lost.
- Flush with 2 held entries, no issue, drop_cnt=0 -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=0, drop_cnt=2, in_ready=1; in_valid in the flush cycle is dropped.
- Saturation: CNT_W=2, four flushes of 1 entry each -> drop_cnt 1,2,3,3.
- SKID=0: out_valid=1, out_ready=0 -> in_ready=0 combinationally in the same cycle; set out_ready=1 -> in_ready=1 same cycle, accept and issue on the same edge.
- Async reset mid-stream: assert rst between clock edges while in TWO state -> out_valid=0 and out_instr=NOP_INSTR immediately, without waiting for a clk edge; after release the first accepted entry appears on the next cycle.
